sega_pad_emu: RTL and testbench

- Emulates a Sega Mega Drive gamepad, i.e. the device end of the joystick protocol. It drives the six active-low data lines in response to the host-driven SEL line.
- Used as a bench/board target for the joystick interface and for feeding pad state from a USB/PS2 front end into the Sega port.
- Supports 3-button and 6-button (extended) pad behaviour.
- Runs entirely on clk50.

---
 rtl/sega_pad_emu.sv | 70 +++++++
 tb/tb_sega_pad_emu.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/sega_pad_emu.sv
// Device end of the Mega Drive joystick port: answers the host's SEL strobe with
// 3-button or 6-button pad data on six active-low lines.
module sega_pad_emu #(
   parameter int TIMEOUT_CYC = 75000,
   parameter int TMR_W       = 17
) (
   input  logic        clk50,
   input  logic        reset,
   input  logic        sel,
   input  logic        mode6,
   input  logic [11:0] buttons,
   output logic [5:0]  pad,
   output logic [2:0]  phase
);

   logic             sel_meta;
   logic             sel_s;
   logic             sel_d;
   logic [TMR_W-1:0] timer;
   logic             fall;
   logic             rise;
   logic [5:0]       pad_next;

   assign fall = sel_d & ~sel_s;
   assign rise = ~sel_d & sel_s;

   // Line order is {C/START, B/A, RT, LT, DN, UP}; buttons[5:0] already matches the high-SEL map.
   always_comb begin
      pad_next = ~buttons[5:0];
      if (sel_s) begin
         if (mode6 && phase == 3'd3)
            pad_next = ~{buttons[5], buttons[4], buttons[11], buttons[10], buttons[9], buttons[8]};
      end else if (mode6 && phase == 3'd3) begin
         pad_next = {~buttons[7], ~buttons[6], 4'b0000};
      end else if (mode6 && phase == 3'd4) begin
         pad_next = {~buttons[7], ~buttons[6], 4'b1111};
      end else begin
         pad_next = {~buttons[7], ~buttons[6], 2'b00, ~buttons[1], ~buttons[0]};
      end
   end

   always_ff @(posedge clk50) begin
      if (reset) begin
         sel_meta <= 1'b1;
         sel_s    <= 1'b1;
         sel_d    <= 1'b1;
         timer    <= '0;
         phase    <= 3'd0;
         pad      <= 6'b111111;
      end else begin
         sel_meta <= sel;
         sel_s    <= sel_meta;
         sel_d    <= sel_s;
         pad      <= pad_next;

         // A SEL edge always beats timer expiry in the same cycle.
         if (fall || rise) begin
            timer <= '0;
            if (fall && phase != 3'd4)
               phase <= phase + 3'd1;
         end else if (timer == TMR_W'(TIMEOUT_CYC - 1)) begin
            timer <= '0;
            phase <= 3'd0;
         end else begin
            timer <= timer + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sega_pad_emu.sv
// Directed bench for sega_pad_emu: table of SEL/button steps plus hand sequences
// for edge latency, the inactivity timeout and reset in the middle of a read.
module tb_sega_pad_emu;

   typedef struct {
      logic        sel;
      logic        m6;
      logic [11:0] btn;
      int          hold;
      logic [5:0]  exp_pad;
      logic [2:0]  exp_phase;
   } vec_t;

   logic        clk50 = 1'b0;
   logic        reset = 1'b1;
   logic        sel = 1'b1;
   logic        mode6 = 1'b1;
   logic [11:0] buttons = 12'h000;
   logic [5:0]  pad;
   logic [2:0]  phase;

   int checks = 0;
   int errors = 0;
   vec_t tbl[0:26];

   sega_pad_emu dut (
      .clk50   (clk50),
      .reset   (reset),
      .sel     (sel),
      .mode6   (mode6),
      .buttons (buttons),
      .pad     (pad),
      .phase   (phase)
   );

   always #10 clk50 = ~clk50;

   task automatic tick(input int n);
      repeat (n) @(negedge clk50);
   endtask

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %02h expected %02h", name, got, exp);
      end else begin
         $display("ok   %s: %02h", name, got);
      end
   endtask

   task automatic apply_vec(input int i);
      sel     = tbl[i].sel;
      mode6   = tbl[i].m6;
      buttons = tbl[i].btn;
      tick(tbl[i].hold);
      check($sformatf("vec%0d pad", i), {2'b00, pad}, {2'b00, tbl[i].exp_pad});
      check($sformatf("vec%0d phase", i), {5'b0, phase}, {5'b0, tbl[i].exp_phase});
   endtask

   task automatic do_reset(input logic s, input logic m6, input logic [11:0] b);
      sel = s; mode6 = m6; buttons = b;
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
   endtask

   initial begin
      // 6-button read, first two lows and highs
      tbl[0]  = '{1'b1, 1'b1, 12'h0C0, 10,  6'h3F, 3'd0};
      tbl[1]  = '{1'b0, 1'b1, 12'h0C0, 100, 6'h03, 3'd1};
      tbl[2]  = '{1'b1, 1'b1, 12'h0C0, 100, 6'h3F, 3'd1};
      tbl[3]  = '{1'b0, 1'b1, 12'h0C0, 100, 6'h03, 3'd2};
      tbl[4]  = '{1'b1, 1'b1, 12'h0C0, 100, 6'h3F, 3'd2};
      // after the third low (hand sequence): extended buttons, then phase 4
      tbl[5]  = '{1'b1, 1'b1, 12'h1C0, 100, 6'h3E, 3'd3};
      tbl[6]  = '{1'b0, 1'b1, 12'h1C0, 100, 6'h0F, 3'd4};
      tbl[7]  = '{1'b1, 1'b1, 12'h1C0, 100, 6'h3F, 3'd4};
      tbl[8]  = '{1'b0, 1'b1, 12'h1C0, 100, 6'h0F, 3'd4};
      // 3-button pad: B+RT+DN+A+START pressed, never an ID pattern
      tbl[9]  = '{1'b1, 1'b0, 12'h0DA, 10,  6'h25, 3'd0};
      tbl[10] = '{1'b0, 1'b0, 12'h0DA, 100, 6'h01, 3'd1};
      tbl[11] = '{1'b1, 1'b0, 12'h0DA, 100, 6'h25, 3'd1};
      tbl[12] = '{1'b0, 1'b0, 12'h0DA, 100, 6'h01, 3'd2};
      tbl[13] = '{1'b1, 1'b0, 12'h0DA, 100, 6'h25, 3'd2};
      tbl[14] = '{1'b0, 1'b0, 12'h0DA, 100, 6'h01, 3'd3};
      tbl[15] = '{1'b1, 1'b0, 12'h0DA, 100, 6'h25, 3'd3};
      tbl[16] = '{1'b0, 1'b0, 12'h0DA, 100, 6'h01, 3'd4};
      tbl[17] = '{1'b1, 1'b0, 12'h0DA, 100, 6'h25, 3'd4};
      // mode6 switched at phase 4 takes effect on the next evaluation
      tbl[18] = '{1'b0, 1'b0, 12'h0DA, 100, 6'h01, 3'd4};
      tbl[19] = '{1'b0, 1'b1, 12'h0DA, 2,   6'h0F, 3'd4};
      // reset-mid-read setup: three lows in 6-button mode
      tbl[20] = '{1'b1, 1'b1, 12'h0C0, 10,  6'h3F, 3'd0};
      tbl[21] = '{1'b0, 1'b1, 12'h0C0, 100, 6'h03, 3'd1};
      tbl[22] = '{1'b1, 1'b1, 12'h0C0, 100, 6'h3F, 3'd1};
      tbl[23] = '{1'b0, 1'b1, 12'h0C0, 100, 6'h03, 3'd2};
      tbl[24] = '{1'b1, 1'b1, 12'h0C0, 100, 6'h3F, 3'd2};
      tbl[25] = '{1'b0, 1'b1, 12'h0C0, 100, 6'h00, 3'd3};
      tbl[26] = '{1'b0, 1'b1, 12'h0C0, 5,   6'h00, 3'd3};

      // Reset state, then a button change one cycle later
      reset = 1'b1;
      tick(2);
      check("reset pad", {2'b00, pad}, 8'h3F);
      check("reset phase", {5'b0, phase}, 8'h00);
      reset = 1'b0;
      tick(1);
      check("idle pad", {2'b00, pad}, 8'h3F);
      buttons = 12'h021;
      tick(1);
      check("up+c pad", {2'b00, pad}, 8'h1E);

      for (int i = 0; i <= 4; i++) apply_vec(i);

      // Third low: phase moves 3 edges after the pin, ID pattern valid after 4
      sel = 1'b0;
      tick(2);
      check("lat phase@2", {5'b0, phase}, 8'h02);
      tick(1);
      check("lat phase@3", {5'b0, phase}, 8'h03);
      tick(1);
      check("lat pad@4", {2'b00, pad}, 8'h00);
      tick(96);

      for (int i = 5; i <= 8; i++) apply_vec(i);

      // Timeout: rise reaches the edge detector on the 3rd edge, expiry 75000 edges later
      sel = 1'b1;
      tick(75002);
      check("timeout phase before", {5'b0, phase}, 8'h04);
      tick(1);
      check("timeout phase after", {5'b0, phase}, 8'h00);
      buttons = 12'h0C0;
      sel = 1'b0;
      tick(100);
      check("post-timeout pad", {2'b00, pad}, 8'h03);
      check("post-timeout phase", {5'b0, phase}, 8'h01);

      do_reset(1'b1, 1'b0, 12'h0DA);
      for (int i = 9; i <= 19; i++) apply_vec(i);

      do_reset(1'b1, 1'b1, 12'h0C0);
      for (int i = 20; i <= 26; i++) apply_vec(i);

      // Reset while SEL is low at phase 3, then release with SEL still low
      reset = 1'b1;
      tick(1);
      check("midreset pad", {2'b00, pad}, 8'h3F);
      check("midreset phase", {5'b0, phase}, 8'h00);
      reset = 1'b0;
      tick(2);
      check("release phase@2", {5'b0, phase}, 8'h00);
      tick(1);
      check("release phase@3", {5'b0, phase}, 8'h01);
      check("release pad@3", {2'b00, pad}, 8'h03);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
